mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIM, default 4: the maximum number of consecutive data grants issued while a fetch request waits.
REQ-002 clk  input  1  global clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 hlt  input  1  halt; blocks new grants.
REQ-005 i_req  input  1  fetch request; held high until i_ack.
REQ-006 i_addr  input  16  fetch address; stable while i_req is high.
REQ-007 i_ack  output  1  fetch complete, one-cycle pulse.
REQ-008 i_rdata  output  16  fetch read data; valid while i_ack is high.
REQ-009 d_req  input  1  data request; held high until d_ack.
REQ-010 d_we  input  1  data write enable (1 = write, 0 = read); stable while d_req is high.
REQ-011 d_addr  input  16  data address; stable while d_req is high.
REQ-012 d_wdata  input  16  data write data; stable while d_req is high.
REQ-013 d_ack  output  1  data complete, one-cycle pulse.
REQ-014 d_rdata  output  16  data read data; valid while d_ack is high for a read.
REQ-015 mem_req  output  1  shared memory request; held high until mem_ack.
REQ-016 mem_we  output  1  shared memory write enable.
REQ-017 mem_addr  output  16  shared memory address.
REQ-018 mem_wdata  output  16  shared memory write data.
REQ-019 mem_rdata  input  16  shared memory read data; valid when mem_ack is high.
REQ-020 mem_ack  input  1  shared memory completion; variable latency of 1 or more cycles.
REQ-021 idle  output  1  high when the FSM is in IDLE.

Function
REQ-022 The FSM SHALL have exactly four states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: hlt=0 and at least one request high -> BUSY_I or BUSY_D at the next edge. Otherwise stay in IDLE.
- BUSY_x: mem_ack=1 -> RESP. Otherwise stay in BUSY_x.
- RESP: -> IDLE unconditionally. No grant decision is made in RESP.
REQ-023 Grant priority in IDLE:
- Only one of d_req/i_req high: grant that requester.
- Both high: grant data, unless starve_cnt == STARVE_LIM, in which case grant fetch.
REQ-024 starve_cnt SHALL be 3 bits wide and update on each grant:
- Data grant with i_req=1: increment, saturating at STARVE_LIM.
- Data grant with i_req=0: clear to 0.
- Fetch grant: clear to 0.
REQ-025 On the granting edge, the winner's addr/we/wdata SHALL be registered into the mem_* outputs. Fetch grants SHALL force mem_we=0 and mem_wdata=0.
REQ-026 mem_req SHALL be a registered output, high in every BUSY_x cycle and low in all other states.
REQ-027 mem_addr, mem_we and mem_wdata SHALL hold constant throughout BUSY_x.
REQ-028 On the edge where mem_ack=1 in BUSY_x:
- mem_rdata SHALL be registered into x_rdata.
- x_ack SHALL be high for exactly the RESP cycle.
REQ-029 x_rdata SHALL hold its value until the next completion for that requester. d_rdata SHALL be unchanged after a data write.
REQ-030 mem_ack in IDLE or RESP SHALL be ignored, with no state change and no ack pulse.
REQ-031 Minimum transaction length SHALL be 3 cycles from grant edge to return to IDLE (grant edge, BUSY with mem_ack=1, RESP).
REQ-032 hlt=1 SHALL block grants only in IDLE. A transaction in BUSY_x SHALL run to completion, including RESP. idle=1 once the FSM returns to IDLE.
REQ-033 A request that is deasserted before it is granted SHALL be dropped without side effects.
REQ-034 i_ack and d_ack SHALL never be high in the same cycle. At most one memory transaction SHALL be outstanding at any time.

Reset
REQ-035 rst_n=0 SHALL asynchronously force the following, including mid-transaction:
- state=IDLE, starve_cnt=0
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
- i_ack=0, d_ack=0, i_rdata=0, d_rdata=0
- idle=1
REQ-036 After rst_n rises, the first grant SHALL be decided at the first rising clk edge with a request high.

Verification
REQ-037 Single fetch:
- Stimulus: i_addr=0x0010, mem_ack after 2 cycles, mem_rdata=0xA5A5.
- Response: mem_addr=0x0010, mem_we=0; i_ack pulses for 1 cycle with i_rdata=0xA5A5; idle=1 the following cycle.
REQ-038 Data write:
- Stimulus: d_we=1, d_addr=0x8000, d_wdata=0x1234.
- Response: mem_we=1, mem_wdata=0x1234; d_ack pulse; d_rdata unchanged.
REQ-039 Simultaneous requests:
- Stimulus: i_req and d_req high continuously, mem_ack=1 in the first BUSY cycle, STARVE_LIM=4.
- Response: grant order D,D,D,D,I,D,D,D,D,I; never more than 4 consecutive D.
REQ-040 Halt:
- Stimulus: raise hlt during BUSY_D, with i_req pending.
- Response: the data transaction completes with d_ack; no fetch grant while hlt=1; fetch is granted at the first IDLE edge after hlt=0.
REQ-041 Reset mid-operation:
- Stimulus: pulse rst_n low in BUSY_I (between edges).
- Response: mem_req drops immediately and no i_ack occurs; after release, a held i_req restarts from the grant.
REQ-042 Spurious acknowledge:
- Stimulus: mem_ack=1 while in IDLE with no requests.
- Response: no ack pulses; state remains IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, shared-memory and status signals around the fetch/data arbiter.
// The arbiter takes the slave view; the environment driving it takes the master view.
interface mem_arbiter_if;
  logic        hlt;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ack;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        idle;

  modport slave (
    input  hlt, i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, idle
  );

  modport master (
    output hlt, i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, idle
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory port, one transaction
// at a time; data wins ties unless fetch has waited through STARVE_LIM data grants.
module mem_arbiter #(
  parameter int STARVE_LIM = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  localparam logic [2:0] LIM = 3'(STARVE_LIM);

  state_t      state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        idle_q, idle_d;
  logic        data_wins;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    data_wins   = bus.d_req && !(bus.i_req && (starve_q == LIM));

    case (state_q)
      IDLE: begin
        if (!bus.hlt && (bus.i_req || bus.d_req)) begin
          mem_req_d = 1'b1;
          if (data_wins) begin
            state_d     = BUSY_D;
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            // Only data grants that leave a fetch waiting count towards starvation.
            if (!bus.i_req) begin
              starve_d = 3'd0;
            end else if (starve_q != LIM) begin
              starve_d = starve_q + 3'd1;
            end
          end else begin
            state_d     = BUSY_I;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.i_addr;
            mem_wdata_d = 16'h0000;
            starve_d    = 3'd0;
          end
        end
      end
      BUSY_I: begin
        if (bus.mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          i_ack_d   = 1'b1;
          i_rdata_d = bus.mem_rdata;
        end
      end
      BUSY_D: begin
        if (bus.mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          d_ack_d   = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    idle_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= 3'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= 16'h0000;
      d_rdata_q   <= 16'h0000;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      idle_q      <= idle_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.idle      = idle_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change and outputs are checked on the falling
// clock edge, with every expected value worked out by hand.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIM(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic hlt, input logic i_req, input logic d_req,
                               input logic mem_ack, input logic [15:0] mem_rdata);
    bus.hlt       = hlt;
    bus.i_req     = i_req;
    bus.d_req     = d_req;
    bus.mem_ack   = mem_ack;
    bus.mem_rdata = mem_rdata;
  endtask

  // The two acknowledges must never overlap in any cycle outside reset.
  always @(negedge clk) begin
    if (rst_n) checkOutput("ack_exclusive", {31'd0, bus.i_ack & bus.d_ack}, 32'd0);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] exp_order;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    bus.i_addr  = 16'h0000;
    bus.d_we    = 1'b0;
    bus.d_addr  = 16'h0000;
    bus.d_wdata = 16'h0000;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    checkOutput("rst_idle", {31'd0, bus.idle}, 32'd1);
    checkOutput("rst_acks", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
    rst_n = 1'b1;

    // Single fetch, memory answers on the second BUSY cycle
    @(negedge clk);
    bus.i_addr = 16'h0010;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("f_mem_req", {31'd0, bus.mem_req}, 32'd1);
    checkOutput("f_mem_addr", {16'd0, bus.mem_addr}, 32'h0010);
    checkOutput("f_mem_we", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("f_idle_busy", {31'd0, bus.idle}, 32'd0);
    @(negedge clk);
    checkOutput("f_mem_req_hold", {31'd0, bus.mem_req}, 32'd1);
    checkOutput("f_no_ack_yet", {31'd0, bus.i_ack}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'hA5A5);
    @(negedge clk);
    checkOutput("f_i_ack", {31'd0, bus.i_ack}, 32'd1);
    checkOutput("f_i_rdata", {16'd0, bus.i_rdata}, 32'hA5A5);
    checkOutput("f_mem_req_resp", {31'd0, bus.mem_req}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("f_i_ack_pulse", {31'd0, bus.i_ack}, 32'd0);
    checkOutput("f_idle_after", {31'd0, bus.idle}, 32'd1);

    // Data read so a later write can show d_rdata is left alone
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0200;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("dr_mem_addr", {16'd0, bus.mem_addr}, 32'h0200);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h5A5A);
    @(negedge clk);
    checkOutput("dr_d_ack", {31'd0, bus.d_ack}, 32'd1);
    checkOutput("dr_d_rdata", {16'd0, bus.d_rdata}, 32'h5A5A);
    checkOutput("dr_i_rdata_hold", {16'd0, bus.i_rdata}, 32'hA5A5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);

    // Data write
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h8000;
    bus.d_wdata = 16'h1234;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("dw_mem_we", {31'd0, bus.mem_we}, 32'd1);
    checkOutput("dw_mem_addr", {16'd0, bus.mem_addr}, 32'h8000);
    checkOutput("dw_mem_wdata", {16'd0, bus.mem_wdata}, 32'h1234);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    @(negedge clk);
    checkOutput("dw_d_ack", {31'd0, bus.d_ack}, 32'd1);
    checkOutput("dw_d_rdata_kept", {16'd0, bus.d_rdata}, 32'h5A5A);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("dw_idle", {31'd0, bus.idle}, 32'd1);

    // Both requesters held high: expected grant order D,D,D,D,I,D,D,D,D,I (1 = data)
    exp_order   = 10'b1111011110;
    bus.i_addr  = 16'h0040;
    bus.d_we    = 1'b0;
    bus.d_addr  = 16'h3000;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("st_addr_%0d", i), {16'd0, bus.mem_addr},
                  exp_order[9-i] ? 32'h3000 : 32'h0040);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'(i));
      @(negedge clk);
      checkOutput($sformatf("st_dack_%0d", i), {31'd0, bus.d_ack}, {31'd0, exp_order[9-i]});
      checkOutput($sformatf("st_iack_%0d", i), {31'd0, bus.i_ack}, {31'd0, ~exp_order[9-i]});
      if (i == 9) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      else        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      @(negedge clk);
    end
    checkOutput("st_idle_end", {31'd0, bus.idle}, 32'd1);

    // Halt raised during a data transaction with a fetch pending
    bus.d_addr = 16'h0700;
    bus.i_addr = 16'h0070;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("h_data_first", {16'd0, bus.mem_addr}, 32'h0700);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("h_busy_holds", {31'd0, bus.mem_req}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h0F0F);
    @(negedge clk);
    checkOutput("h_d_ack", {31'd0, bus.d_ack}, 32'd1);
    checkOutput("h_d_rdata", {16'd0, bus.d_rdata}, 32'h0F0F);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("h_blocked_req_%0d", i), {31'd0, bus.mem_req}, 32'd0);
      checkOutput($sformatf("h_blocked_idle_%0d", i), {31'd0, bus.idle}, 32'd1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("h_fetch_req", {31'd0, bus.mem_req}, 32'd1);
    checkOutput("h_fetch_addr", {16'd0, bus.mem_addr}, 32'h0070);
    checkOutput("h_fetch_we", {31'd0, bus.mem_we}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'h1111);
    @(negedge clk);
    checkOutput("h_i_ack", {31'd0, bus.i_ack}, 32'd1);
    checkOutput("h_i_rdata", {16'd0, bus.i_rdata}, 32'h1111);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);

    // Reset pulse in the middle of a fetch; the held request must restart cleanly
    bus.i_addr = 16'h0099;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("r_busy", {31'd0, bus.mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("r_mem_req_drop", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("r_idle", {31'd0, bus.idle}, 32'd1);
    checkOutput("r_i_rdata", {16'd0, bus.i_rdata}, 32'd0);
    checkOutput("r_d_rdata", {16'd0, bus.d_rdata}, 32'd0);
    checkOutput("r_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("r_regrant_req", {31'd0, bus.mem_req}, 32'd1);
    checkOutput("r_regrant_addr", {16'd0, bus.mem_addr}, 32'h0099);
    checkOutput("r_no_i_ack", {31'd0, bus.i_ack}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'h2222);
    @(negedge clk);
    checkOutput("r_i_ack", {31'd0, bus.i_ack}, 32'd1);
    checkOutput("r_i_rdata_new", {16'd0, bus.i_rdata}, 32'h2222);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);

    // Spurious memory acknowledge while idle
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'hDEAD);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("sp_acks_%0d", i), {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
      checkOutput($sformatf("sp_idle_%0d", i), {31'd0, bus.idle}, 32'd1);
      checkOutput($sformatf("sp_req_%0d", i), {31'd0, bus.mem_req}, 32'd0);
    end

    // A data request withdrawn while halted leaves no trace
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("drop_idle", {31'd0, bus.idle}, 32'd1);
    checkOutput("drop_req", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("drop_d_ack", {31'd0, bus.d_ack}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
